// File: rtl/optr_event_sched.sv
// Event scheduler: drains the ack / offload-done / write-done FIFOs into one tagged event
// stream toward Optr using weighted round-robin with a single event holding register.
module optr_event_sched #(
   parameter int unsigned ACK_WEIGHT = 2,
   localparam int unsigned DATA_W = 28,
   localparam int unsigned TID_W  = 8,
   localparam int unsigned SEQ_W  = 8,
   localparam int unsigned TYPE_W = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              schedEnable,
   input  logic              ackFifoEmpty,
   output logic              ackFifoPop,
   input  logic [DATA_W-1:0] ackFifoDataOut,
   input  logic              offloadFifoEmpty,
   output logic              offloadFifoPop,
   input  logic [TID_W-1:0]  offloadFifoDataOut,
   input  logic              wrDoneFifoEmpty,
   output logic              wrDoneFifoPop,
   input  logic [TID_W-1:0]  wrDoneFifoDataOut,
   output logic              evtValid,
   input  logic              evtReady,
   output logic [TYPE_W-1:0] evtType,
   output logic [DATA_W-1:0] evtData,
   output logic [SEQ_W-1:0]  evtSeq,
   output logic              schedBusy
);

   localparam int unsigned BURST_W = 3;
   localparam int unsigned PAD_W   = DATA_W - TID_W;

   localparam logic [TYPE_W-1:0] EVT_ACK = 2'd0;
   localparam logic [TYPE_W-1:0] EVT_OFF = 2'd1;
   localparam logic [TYPE_W-1:0] EVT_WRD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ISSUE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [TYPE_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [BURST_W-1:0]  ack_burst_q, ack_burst_d;
   logic [TYPE_W-1:0]   evt_type_q, evt_type_d;
   logic [DATA_W-1:0]   evt_data_q, evt_data_d;
   logic [SEQ_W-1:0]    evt_seq_q, evt_seq_d;

   logic [3:0]          avail_c;
   logic [TYPE_W-1:0]   cand1_c, cand2_c, cand3_c;
   logic [TYPE_W-1:0]   grant_c;
   logic                grant_fire_c;

   function automatic logic [TYPE_W-1:0] rr_inc(input logic [TYPE_W-1:0] p);
      return (p == EVT_WRD) ? EVT_ACK : TYPE_W'(p + 2'd1);
   endfunction

   // Search order starts at rr_ptr; entry 3 pads the lookup and is never available.
   always_comb begin
      avail_c = {1'b0, ~wrDoneFifoEmpty, ~offloadFifoEmpty, ~ackFifoEmpty};
      cand1_c = rr_ptr_q;
      cand2_c = rr_inc(cand1_c);
      cand3_c = rr_inc(cand2_c);
      if (avail_c[cand1_c])      grant_c = cand1_c;
      else if (avail_c[cand2_c]) grant_c = cand2_c;
      else                       grant_c = cand3_c;
      // Pops are combinational, so hold them off while reset is asserted.
      grant_fire_c = reset & schedEnable & (|avail_c[2:0]) & (state_q == ST_IDLE);
   end

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (grant_fire_c) state_d = ST_FETCH;
         ST_FETCH: state_d = ST_ISSUE;
         ST_ISSUE: if (evtReady) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      ackFifoPop     = grant_fire_c & (grant_c == EVT_ACK);
      offloadFifoPop = grant_fire_c & (grant_c == EVT_OFF);
      wrDoneFifoPop  = grant_fire_c & (grant_c == EVT_WRD);
      evtValid       = (state_q == ST_ISSUE);
      schedBusy      = (state_q != ST_IDLE);
   end

   // Arbitration pointer, event holding register and sequence counter updates
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      ack_burst_d = ack_burst_q;
      evt_type_d  = evt_type_q;
      evt_data_d  = evt_data_q;
      evt_seq_d   = evt_seq_q;

      if (grant_fire_c) begin
         evt_type_d = grant_c;
         if ((grant_c == EVT_ACK) && ((32'(ack_burst_q) + 32'd1) < ACK_WEIGHT)) begin
            rr_ptr_d    = EVT_ACK;
            ack_burst_d = BURST_W'(ack_burst_q + 3'd1);
         end else begin
            rr_ptr_d    = rr_inc(grant_c);
            ack_burst_d = '0;
         end
      end

      if (state_q == ST_FETCH) begin
         case (evt_type_q)
            EVT_ACK: evt_data_d = ackFifoDataOut;
            EVT_OFF: evt_data_d = {PAD_W'(0), offloadFifoDataOut};
            default: evt_data_d = {PAD_W'(0), wrDoneFifoDataOut};
         endcase
      end

      if ((state_q == ST_ISSUE) && evtReady) evt_seq_d = SEQ_W'(evt_seq_q + 8'd1);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr_q    <= EVT_ACK;
         ack_burst_q <= '0;
         evt_type_q  <= '0;
         evt_data_q  <= '0;
         evt_seq_q   <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         ack_burst_q <= ack_burst_d;
         evt_type_q  <= evt_type_d;
         evt_data_q  <= evt_data_d;
         evt_seq_q   <= evt_seq_d;
      end
   end

   assign evtType = evt_type_q;
   assign evtData = evt_data_q;
   assign evtSeq  = evt_seq_q;

endmodule

// File: tb/tb_optr_event_sched.sv
// Scoreboard bench for optr_event_sched: FIFO models, a reference arbiter model and directed
// plus randomized traffic.
module tb_optr_event_sched;

   localparam int ACK_WEIGHT = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        schedEnable = 1'b0;
   logic        ackFifoEmpty = 1'b1;
   logic        ackFifoPop;
   logic [27:0] ackFifoDataOut = '0;
   logic        offloadFifoEmpty = 1'b1;
   logic        offloadFifoPop;
   logic [7:0]  offloadFifoDataOut = '0;
   logic        wrDoneFifoEmpty = 1'b1;
   logic        wrDoneFifoPop;
   logic [7:0]  wrDoneFifoDataOut = '0;
   logic        evtValid;
   logic        evtReady = 1'b0;
   logic [1:0]  evtType;
   logic [27:0] evtData;
   logic [7:0]  evtSeq;
   logic        schedBusy;

   optr_event_sched #(.ACK_WEIGHT(ACK_WEIGHT)) dut (
      .clock              (clock),
      .reset              (reset),
      .schedEnable        (schedEnable),
      .ackFifoEmpty       (ackFifoEmpty),
      .ackFifoPop         (ackFifoPop),
      .ackFifoDataOut     (ackFifoDataOut),
      .offloadFifoEmpty   (offloadFifoEmpty),
      .offloadFifoPop     (offloadFifoPop),
      .offloadFifoDataOut (offloadFifoDataOut),
      .wrDoneFifoEmpty    (wrDoneFifoEmpty),
      .wrDoneFifoPop      (wrDoneFifoPop),
      .wrDoneFifoDataOut  (wrDoneFifoDataOut),
      .evtValid           (evtValid),
      .evtReady           (evtReady),
      .evtType            (evtType),
      .evtData            (evtData),
      .evtSeq             (evtSeq),
      .schedBusy          (schedBusy)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [1:0]  typ;
      logic [27:0] data;
      logic [7:0]  seq;
   } evt_t;

   logic [27:0] q_ack[$];
   logic [7:0]  q_off[$];
   logic [7:0]  q_wrd[$];
   evt_t        sb[$];
   int          obs_q[$];
   int          checks = 0;
   int          errors = 0;
   int          hs_cnt = 0;
   int          wrap_cnt = 0;
   int          last_hs_seq = -1;
   int          m_rr = 0;
   int          m_burst = 0;
   int          m_age = -1;
   logic [7:0]  m_seq = '0;
   logic [2:0]  s_pop = '0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
      end
   endfunction

   function automatic int qsize(input int c);
      case (c)
         0:       return q_ack.size();
         1:       return q_off.size();
         default: return q_wrd.size();
      endcase
   endfunction

   function automatic logic [27:0] qfront(input int c);
      case (c)
         0:       return q_ack[0];
         1:       return {20'd0, q_off[0]};
         default: return {20'd0, q_wrd[0]};
      endcase
   endfunction

   task automatic refresh_flags();
      ackFifoEmpty     = (q_ack.size() == 0);
      offloadFifoEmpty = (q_off.size() == 0);
      wrDoneFifoEmpty  = (q_wrd.size() == 0);
   endtask

   task automatic push(input int c, input logic [27:0] v);
      case (c)
         0:       q_ack.push_back(v);
         1:       q_off.push_back(v[7:0]);
         default: q_wrd.push_back(v[7:0]);
      endcase
      refresh_flags();
   endtask

   // FIFO models: pops sampled mid-cycle take effect just after the edge (1-cycle read latency)
   always @(posedge clock) begin
      logic [2:0] p;
      p = s_pop;
      #1;
      if (p[0] && q_ack.size() > 0) ackFifoDataOut     = q_ack.pop_front();
      if (p[1] && q_off.size() > 0) offloadFifoDataOut = q_off.pop_front();
      if (p[2] && q_wrd.size() > 0) wrDoneFifoDataOut  = q_wrd.pop_front();
      refresh_flags();
   end

   // Reference model and monitor, sampled on the falling edge
   always @(negedge clock) begin
      int g;
      logic [2:0] exp_pop;
      evt_t e;
      s_pop = {wrDoneFifoPop, offloadFifoPop, ackFifoPop};
      if (s_pop == 3'b001)      obs_q.push_back(0);
      else if (s_pop == 3'b010) obs_q.push_back(1);
      else if (s_pop == 3'b100) obs_q.push_back(2);
      else if (s_pop != 3'b000) obs_q.push_back(3);

      if (!reset) begin
         chk("rst_pops",  32'(s_pop), 32'd0);
         chk("rst_valid", 32'(evtValid), 32'd0);
         chk("rst_seq",   32'(evtSeq), 32'd0);
         chk("rst_type",  32'(evtType), 32'd0);
         chk("rst_data",  32'(evtData), 32'd0);
         chk("rst_busy",  32'(schedBusy), 32'd0);
         m_rr = 0; m_burst = 0; m_age = -1; m_seq = '0;
         sb.delete();
      end else if (m_age < 0) begin
         chk("idle_busy",  32'(schedBusy), 32'd0);
         chk("idle_valid", 32'(evtValid), 32'd0);
         g = -1;
         if (schedEnable) begin
            for (int k = 0; k < 3; k++) begin
               if (g < 0 && qsize((m_rr + k) % 3) > 0) g = (m_rr + k) % 3;
            end
         end
         exp_pop = (g >= 0) ? 3'(1 << g) : 3'b000;
         chk("pop", 32'(s_pop), 32'(exp_pop));
         if (g >= 0) begin
            e.typ  = 2'(g);
            e.data = qfront(g);
            e.seq  = m_seq;
            sb.push_back(e);
            m_seq = 8'(m_seq + 8'd1);
            if (g == 0 && m_burst + 1 < ACK_WEIGHT) begin
               m_rr = 0;
               m_burst++;
            end else begin
               m_rr = (g + 1) % 3;
               m_burst = 0;
            end
            m_age = 1;
         end
      end else begin
         chk("busy",     32'(schedBusy), 32'd1);
         chk("busy_pop", 32'(s_pop), 32'd0);
         if (m_age == 1) begin
            chk("fetch_valid", 32'(evtValid), 32'd0);
            m_age = 2;
         end else begin
            chk("issue_valid", 32'(evtValid), 32'd1);
            if (sb.size() > 0) begin
               chk("evt_type", 32'(evtType), 32'(sb[0].typ));
               chk("evt_data", 32'(evtData), 32'(sb[0].data));
               chk("evt_seq",  32'(evtSeq),  32'(sb[0].seq));
               if (evtReady) begin
                  if (last_hs_seq == 255 && evtSeq == 8'd0) wrap_cnt++;
                  last_hs_seq = int'(evtSeq);
                  void'(sb.pop_front());
                  hs_cnt++;
                  m_age = -1;
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic wait_hs(input int target, input string nm);
      int b = 3000;
      while (hs_cnt < target && b > 0) begin tick(1); b--; end
      chk(nm, 32'(hs_cnt >= target), 32'd1);
   endtask

   task automatic wait_valid(input string nm);
      int b = 200;
      while (!evtValid && b > 0) begin tick(1); b--; end
      chk(nm, 32'(evtValid), 32'd1);
   endtask

   task automatic wait_obs(input int n, input string nm);
      int b = 200;
      while (obs_q.size() < n && b > 0) begin tick(1); b--; end
      chk(nm, 32'(obs_q.size() >= n), 32'd1);
   endtask

   task automatic drain(input string nm);
      int b = 3000;
      schedEnable = 1'b1;
      evtReady = 1'b1;
      while ((q_ack.size() + q_off.size() + q_wrd.size() > 0 || m_age >= 0) && b > 0) begin
         tick(1);
         b--;
      end
      tick(1);
      chk(nm, 32'(schedBusy), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;
      int b;
      int exp_order[10] = '{0, 0, 1, 2, 0, 0, 1, 2, 1, 2};
      reset = 1'b1;
      #1 reset = 1'b0;
      tick(3);
      reset = 1'b1;

      // Single offload event
      obs_q.delete();
      push(1, 28'h5A);
      evtReady = 1'b1;
      schedEnable = 1'b1;
      wait_valid("t1_valid");
      chk("t1_type", 32'(evtType), 32'd1);
      chk("t1_data", 32'(evtData), 32'h5A);
      chk("t1_seq0", 32'(evtSeq), 32'd0);
      wait_hs(1, "t1_hs");
      tick(2);
      chk("t1_seq1", 32'(evtSeq), 32'd1);
      chk("t1_src", 32'(obs_q[0]), 32'd1);

      // Weighted round-robin order with all FIFOs full
      do_reset();
      obs_q.delete();
      base = hs_cnt;
      for (int i = 0; i < 4; i++) begin
         push(0, 28'($urandom));
         push(1, 28'($urandom));
         push(2, 28'($urandom));
      end
      wait_hs(base + 12, "t2_hs");
      for (int i = 0; i < 10; i++) chk($sformatf("t2_order%0d", i), 32'(obs_q[i]), 32'(exp_order[i]));

      // Backpressure hold with other FIFOs waiting
      evtReady = 1'b0;
      push(0, 28'hABCDEF1);
      wait_valid("t3_valid");
      n = obs_q.size();
      push(1, 28'h33);
      push(2, 28'h44);
      tick(10);
      chk("t3_nopop", 32'(obs_q.size()), 32'(n));
      base = hs_cnt;
      evtReady = 1'b1;
      wait_hs(base + 1, "t3_hs");
      drain("t3_drain");

      // Ack-only traffic falls back to ack after rotation
      do_reset();
      obs_q.delete();
      base = hs_cnt;
      for (int i = 0; i < 6; i++) push(0, 28'($urandom));
      wait_hs(base + 6, "t4_hs");
      tick(2);
      chk("t4_cnt", 32'(obs_q.size()), 32'd6);
      for (int i = 0; i < 6; i++) chk($sformatf("t4_src%0d", i), 32'(obs_q[i]), 32'd0);
      chk("t4_seq", 32'(evtSeq), 32'd6);

      // Randomized traffic long enough to wrap the sequence number
      base = hs_cnt;
      b = 8000;
      while (hs_cnt - base < 300 && b > 0) begin
         for (int c = 0; c < 3; c++) begin
            if ($urandom_range(0, 3) == 0 && qsize(c) < 6) push(c, 28'($urandom));
         end
         schedEnable = ($urandom_range(0, 7) != 0);
         evtReady    = ($urandom_range(0, 2) != 0);
         tick(1);
         b--;
      end
      chk("rand_hs", 32'(hs_cnt - base >= 300), 32'd1);
      chk("seq_wrap", 32'(wrap_cnt > 0), 32'd1);
      drain("rand_drain");

      // Disable during FETCH: in-flight event completes, no new grant
      n = obs_q.size();
      push(0, 28'h1234567);
      wait_obs(n + 1, "t5_pop");
      schedEnable = 1'b0;
      base = hs_cnt;
      push(0, 28'h7654321);
      push(1, 28'h55);
      tick(8);
      chk("t5_hs", 32'(hs_cnt), 32'(base + 1));
      chk("t5_nopop", 32'(obs_q.size()), 32'(n + 1));
      drain("t5_drain");

      // Reset while an event is presented
      evtReady = 1'b0;
      push(0, 28'h0FEDCBA);
      wait_valid("t6_valid");
      push(1, 28'h66);
      reset = 1'b0;
      #1;
      chk("t6_valid0", 32'(evtValid), 32'd0);
      chk("t6_busy0",  32'(schedBusy), 32'd0);
      chk("t6_seq0",   32'(evtSeq), 32'd0);
      tick(2);
      obs_q.delete();
      push(0, 28'h0000ACE);
      reset = 1'b1;
      wait_obs(1, "t6_pop");
      chk("t6_first_ack", 32'(obs_q[0]), 32'd0);
      drain("t6_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
